ex_muldiv_sequencer: RTL and testbench
======================================

// Module: ex_muldiv_sequencer
// PURPOSE
//  Multi-cycle MULT/MULTU/DIV/DIVU engine beside the EX-stage ALU. Owns the HI/LO registers.
//  Sequences shift-add multiply and restoring divide, one bit per cycle.
//  Stalls the pipeline when a new mul/div or an MFHI/MFLO read hits while an operation is in flight.
// PARAMETERS
//  NB_DATA  32  operand width; HI/LO each NB_DATA bits
//  NB_CNT    6  iteration counter width, must hold NB_DATA
// PORTS
//  clk            in   1        clock, rising edge
//  i_rst_n        in   1        reset, asynchronous, active-low
//  i_halt         in   1        global halt; freezes all state, HI/LO and counter
//  i_start        in   1        EX holds a mul/div instruction with forwarded operands
//  i_op           in   2        00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//  i_datoA        in   NB_DATA  rs operand, already forwarded (multiplicand / dividend)
//  i_datoB        in   NB_DATA  rt operand, already forwarded (multiplier / divisor)
//  i_hilo_read    in   1        EX holds MFHI/MFLO
//  o_busy         out  1        state != IDLE
//  o_stall        out  1        o_busy & (i_start | i_hilo_read); combinational
//  o_done         out  1        one-cycle pulse; HI/LO updated
//  o_div_by_zero  out  1        pulses with o_done when a DIV/DIVU had a zero divisor
//  o_hi           out  NB_DATA  HI register
//  o_lo           out  NB_DATA  LO register
// BEHAVIOUR
//  Reset (async):
//  - state IDLE, counter 0, all outputs 0, HI = LO = 0.
//  - Asserting reset mid-operation aborts the operation; no o_done is produced.
//  FSM states: IDLE, MUL, DIV, FIX.
//  - IDLE: on i_start & !i_halt, latch the operands and go to MUL or DIV (by i_op[1]).
//    - Signed ops latch |A| and |B|, plus neg_res = sA^sB and neg_rem = sA.
//    - Counter clears to 0.
//  - MUL/DIV: one step per cycle; the counter increments.
//    - At counter == NB_DATA-1 the next state is FIX.
//  - FIX:
//    - Apply sign correction.
//    - Write HI/LO and pulse o_done.
//    - Return to IDLE.
//  Latency: start accepted at edge 0; HI/LO and o_done valid after edge NB_DATA+1 (33 by default).
//  i_halt:
//  - Holds every register.
//  - Latency extends by exactly the number of halted cycles.
//  - o_done is held; it does not re-pulse.
//  Multiply:
//  - 2*NB_DATA-bit accumulator, shift-add.
//  - Signed result = neg_res ? -(|A|*|B|) : |A|*|B| (2*NB_DATA negate).
//  - HI = upper half, LO = lower half.
//  Divide:
//  - Restoring; remainder NB_DATA+1 bits wide.
//  - Signed quotient negated if neg_res; remainder negated if neg_rem.
//  - LO = quotient, HI = remainder.
//  Divisor 0 (signed or unsigned):
//  - LO = all ones, HI = original i_datoA.
//  - o_div_by_zero = 1 with o_done.
//  Signed overflow 0x80000000 / -1: LO = 0x80000000, HI = 0 (falls out of the magnitude path).
//  i_start while busy:
//  - Not accepted. o_stall holds the instruction in EX.
//  - Accepted in the first IDLE cycle after FIX.
//  - Back-to-back ops therefore have no idle bubble beyond FIX.
//  i_hilo_read:
//  - While busy, stalls.
//  - In IDLE, o_stall = 0; the reader uses o_hi/o_lo directly.
//  - In the FIX cycle, o_stall = 1; the read proceeds next cycle with the updated value.
//  HI/LO change only in FIX (or reset); never during iteration.
// STRUCTURE
//  Shared package muldiv_pkg:
//  - op encodings MULTU/MULT/DIVU/DIV.
//  - FSM state localparams IDLE/MUL/DIV/FIX.
//  One sub-module: ex_muldiv_step.
//  - Combinational single iteration: add-shift or compare-subtract-shift.
//  - Instantiated once; FSM, counter, sign logic and HI/LO remain in the top module.
// TESTING
//  - MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE LO=0x00000001; o_done high after edge 33 exactly.
//  - MULT -3*7 -> HI=0xFFFFFFFF LO=0xFFFFFFEB.
//  - DIV -7/2 -> LO=0xFFFFFFFD HI=0xFFFFFFFF.
//  - DIV 0x80000000/-1 -> LO=0x80000000 HI=0.
//  - DIVU 10/0 -> LO=0xFFFFFFFF HI=0x0000000A, o_div_by_zero=1 for one cycle.
//  - MULTU 5*6 with i_hilo_read at edge 3:
//    - o_stall=1 through the FIX cycle.
//    - i_halt for 5 cycles mid-op moves o_done to edge 38.
//  - Reset pulse at edge 10 of a DIVU -> HI=LO=0, state IDLE, no o_done.
//  - Next start behaves normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer.
//   Op codes : OP_MULTU / OP_MULT / OP_DIVU / OP_DIV. Bit 1 selects divide and bit 0 selects signed.
//   FSM codes: ST_IDLE / ST_MUL / ST_DIV / ST_FIX
package muldiv_pkg;

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_MUL   = 2'd1;
   localparam logic [1:0] ST_DIV   = 2'd2;
   localparam logic [1:0] ST_FIX   = 2'd3;

endpackage

// File: rtl/ex_muldiv_step.sv
// Single combinational iteration of the multiply/divide datapath.
//   i_is_div : 1 = restoring-divide step, 0 = shift-add multiply step
//   i_acc    : accumulator, 2*NB_DATA+1 bits
//              mul: [2N-1:N] partial product, [N-1:0] remaining multiplier bits
//              div: [2N:N] partial remainder, [N-1:0] dividend bits / quotient bits
//   i_opb    : multiplicand (mul) or divisor (div) magnitude
//   o_acc    : accumulator after one step
module ex_muldiv_step #(
   parameter int unsigned NB_DATA = 32
) (
   input  logic                 i_is_div,
   input  logic [2*NB_DATA:0]   i_acc,
   input  logic [NB_DATA-1:0]   i_opb,
   output logic [2*NB_DATA:0]   o_acc
);

   localparam int unsigned N = NB_DATA;

   logic [N:0]   w_sum;
   logic [N+1:0] w_trial;
   logic [N+1:0] w_diff;

   always_comb begin
      // Multiply: add multiplicand when the current multiplier LSB is set, then shift right.
      w_sum   = {1'b0, i_acc[2*N-1:N]} + {1'b0, (i_acc[0] ? i_opb : {N{1'b0}})};
      // Divide: shift the next dividend bit into the remainder, try subtracting the divisor.
      w_trial = i_acc[2*N:N-1];
      w_diff  = w_trial - {2'b00, i_opb};
      if (i_is_div) begin
         if (!w_diff[N+1]) begin
            o_acc = {w_diff[N:0], i_acc[N-2:0], 1'b1};
         end else begin
            o_acc = {w_trial[N:0], i_acc[N-2:0], 1'b0};
         end
      end else begin
         o_acc = {1'b0, w_sum, i_acc[N-1:1]};
      end
   end

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine next to the EX-stage ALU; owns HI/LO.
// One datapath step per cycle. It stalls EX when a new mul/div or an MFHI/MFLO arrives while busy.
//   clk, i_rst_n   : clock, async active-low reset
//   i_halt         : freezes every register
//   i_start, i_op  : mul/div request and opcode (muldiv_pkg OP_*)
//   i_datoA/B      : forwarded rs/rt operands
//   i_hilo_read    : EX holds MFHI/MFLO
//   o_busy/o_stall : engine busy / hold EX
//   o_done         : one-cycle pulse once HI/LO are written
//   o_div_by_zero  : pulses with o_done for a zero divisor
//   o_hi/o_lo      : HI/LO registers
module ex_muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int unsigned NB_DATA = 32,
   parameter int unsigned NB_CNT  = 6
) (
   input  logic               clk,
   input  logic               i_rst_n,
   input  logic               i_halt,
   input  logic               i_start,
   input  logic [1:0]         i_op,
   input  logic [NB_DATA-1:0] i_datoA,
   input  logic [NB_DATA-1:0] i_datoB,
   input  logic               i_hilo_read,
   output logic               o_busy,
   output logic               o_stall,
   output logic               o_done,
   output logic               o_div_by_zero,
   output logic [NB_DATA-1:0] o_hi,
   output logic [NB_DATA-1:0] o_lo
);

   localparam int unsigned N = NB_DATA;
   localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(NB_DATA - 1);

   logic [1:0]        r_state;
   logic [NB_CNT-1:0] r_cnt;
   logic [2*N:0]      r_acc;
   logic [N-1:0]      r_opb;
   logic [N-1:0]      r_dato_a;
   logic              r_neg_res;
   logic              r_neg_rem;
   logic              r_is_div;
   logic [N-1:0]      r_hi;
   logic [N-1:0]      r_lo;
   logic              r_done;
   logic              r_dbz;

   logic              w_sign_a;
   logic              w_sign_b;
   logic [N-1:0]      w_abs_a;
   logic [N-1:0]      w_abs_b;
   logic [2*N:0]      w_step_acc;
   logic [2*N-1:0]    w_prod;
   logic [N-1:0]      w_quot;
   logic [N-1:0]      w_rem;
   logic              w_div_zero;
   logic [N-1:0]      w_fix_hi;
   logic [N-1:0]      w_fix_lo;

   ex_muldiv_step #(
      .NB_DATA (NB_DATA)
   ) u_step (
      .i_is_div (r_is_div),
      .i_acc    (r_acc),
      .i_opb    (r_opb),
      .o_acc    (w_step_acc)
   );

   always_comb begin
      w_sign_a   = i_op[0] & i_datoA[N-1];
      w_sign_b   = i_op[0] & i_datoB[N-1];
      w_abs_a    = w_sign_a ? -i_datoA : i_datoA;
      w_abs_b    = w_sign_b ? -i_datoB : i_datoB;
      w_prod     = r_neg_res ? -r_acc[2*N-1:0] : r_acc[2*N-1:0];
      w_quot     = r_neg_res ? -r_acc[N-1:0]   : r_acc[N-1:0];
      // Final remainder is below the divisor, so its low N bits hold it entirely.
      w_rem      = r_neg_rem ? -r_acc[2*N-1:N] : r_acc[2*N-1:N];
      w_div_zero = r_is_div & (r_opb == '0);
      if (!r_is_div) begin
         w_fix_hi = w_prod[2*N-1:N];
         w_fix_lo = w_prod[N-1:0];
      end else if (w_div_zero) begin
         w_fix_hi = r_dato_a;
         w_fix_lo = {N{1'b1}};
      end else begin
         w_fix_hi = w_rem;
         w_fix_lo = w_quot;
      end
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_acc     <= '0;
         r_opb     <= '0;
         r_dato_a  <= '0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_is_div  <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_done    <= 1'b0;
         r_dbz     <= 1'b0;
      end else if (!i_halt) begin
         r_done <= 1'b0;
         r_dbz  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_state   <= i_op[1] ? ST_DIV : ST_MUL;
                  r_cnt     <= '0;
                  r_is_div  <= i_op[1];
                  r_neg_res <= w_sign_a ^ w_sign_b;
                  r_neg_rem <= w_sign_a;
                  r_dato_a  <= i_datoA;
                  // mul: multiplier |B| shifts through the low half, |A| is added.
                  // div: dividend |A| shifts out of the low half, |B| is subtracted.
                  r_opb     <= i_op[1] ? w_abs_b : w_abs_a;
                  r_acc     <= {{(N+1){1'b0}}, (i_op[1] ? w_abs_a : w_abs_b)};
               end
            end
            ST_MUL, ST_DIV: begin
               r_acc <= w_step_acc;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNT_LAST) begin
                  r_state <= ST_FIX;
               end
            end
            ST_FIX: begin
               r_hi    <= w_fix_hi;
               r_lo    <= w_fix_lo;
               r_done  <= 1'b1;
               r_dbz   <= w_div_zero;
               r_cnt   <= '0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_busy        = (r_state != ST_IDLE);
   assign o_stall       = o_busy & (i_start | i_hilo_read);
   assign o_done        = r_done;
   assign o_div_by_zero = r_dbz;
   assign o_hi          = r_hi;
   assign o_lo          = r_lo;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Self-checking bench for ex_muldiv_sequencer: directed corner cases, stall/halt timing,
// mid-operation reset, back-to-back issue and randomized ops against a plain-arithmetic model.
module tb_ex_muldiv_sequencer;

   logic        clk;
   logic        i_rst_n;
   logic        i_halt;
   logic        i_start;
   logic [1:0]  i_op;
   logic [31:0] i_datoA;
   logic [31:0] i_datoB;
   logic        i_hilo_read;
   logic        o_busy;
   logic        o_stall;
   logic        o_done;
   logic        o_div_by_zero;
   logic [31:0] o_hi;
   logic [31:0] o_lo;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] last_hi = '0;
   logic [31:0] last_lo = '0;

   ex_muldiv_sequencer #(
      .NB_DATA (32),
      .NB_CNT  (6)
   ) dut (
      .clk           (clk),
      .i_rst_n       (i_rst_n),
      .i_halt        (i_halt),
      .i_start       (i_start),
      .i_op          (i_op),
      .i_datoA       (i_datoA),
      .i_datoB       (i_datoB),
      .i_hilo_read   (i_hilo_read),
      .o_busy        (o_busy),
      .o_stall       (o_stall),
      .o_done        (o_done),
      .o_div_by_zero (o_div_by_zero),
      .o_hi          (o_hi),
      .o_lo          (o_lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: MIPS HI/LO semantics from plain 64-bit arithmetic.
   function automatic void ref_model(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] hi,
                                     output logic [31:0] lo, output logic dbz);
      longint      sa, sb, q, r;
      logic [63:0] u;
      sa  = $signed(a);
      sb  = $signed(b);
      dbz = 1'b0;
      if (!op[1]) begin
         if (op[0]) u = sa * sb;
         else       u = {32'd0, a} * {32'd0, b};
         hi = u[63:32];
         lo = u[31:0];
      end else if (b == 32'd0) begin
         hi  = a;
         lo  = 32'hFFFF_FFFF;
         dbz = 1'b1;
      end else if (op[0]) begin
         q  = sa / sb;
         r  = sa % sb;
         lo = q[31:0];
         hi = r[31:0];
      end else begin
         lo = a / b;
         hi = a % b;
      end
   endfunction

   // Issue one op from IDLE; report the edge (start edge = 0) at which o_done was seen.
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int done_edge, output logic [31:0] hi, output logic [31:0] lo,
                        output logic dbz);
      @(negedge clk);
      i_start = 1'b1;
      i_op    = op;
      i_datoA = a;
      i_datoB = b;
      @(posedge clk);
      @(negedge clk);
      i_start   = 1'b0;
      done_edge = -1;
      hi        = o_hi;
      lo        = o_lo;
      dbz       = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (o_done) begin
            done_edge = k;
            hi        = o_hi;
            lo        = o_lo;
            dbz       = o_div_by_zero;
            break;
         end
      end
   endtask

   task automatic test_reset;
      n_tests++;
      if ({o_busy, o_stall, o_done, o_div_by_zero} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b want 0000", {o_busy, o_stall, o_done, o_div_by_zero});
      end
      n_tests++;
      if (o_hi !== 32'd0 || o_lo !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_hilo: got hi=%h lo=%h want 0/0", o_hi, o_lo);
      end
   endtask

   task automatic test_directed;
      logic [1:0]  ops [5];
      logic [31:0] as  [5];
      logic [31:0] bs  [5];
      logic [31:0] ehi, elo, hi, lo;
      logic        edbz, dbz;
      int          de;
      ops = '{2'b00, 2'b01, 2'b11, 2'b11, 2'b10};
      as  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h8000_0000, 32'd10};
      bs  = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0};
      for (int i = 0; i < 5; i++) begin
         ref_model(ops[i], as[i], bs[i], ehi, elo, edbz);
         do_op(ops[i], as[i], bs[i], de, hi, lo, dbz);
         n_tests++;
         if (de !== 33) begin
            n_fail++;
            $display("FAIL dir%0d_latency: got edge %0d want 33", i, de);
         end
         n_tests++;
         if (hi !== ehi || lo !== elo || dbz !== edbz) begin
            n_fail++;
            $display("FAIL dir%0d_result: got hi=%h lo=%h dbz=%b want hi=%h lo=%h dbz=%b",
                     i, hi, lo, dbz, ehi, elo, edbz);
         end
         @(negedge clk);
         n_tests++;
         if (o_done !== 1'b0 || o_div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL dir%0d_pulse: got done=%b dbz=%b want 0/0", i, o_done, o_div_by_zero);
         end
         last_hi = ehi;
         last_lo = elo;
      end
   endtask

   task automatic test_stall_halt;
      int done_edge = -1;
      int bad_stall = 0;
      logic exp_stall;
      @(negedge clk);
      i_start = 1'b1;
      i_op    = 2'b00;
      i_datoA = 32'd5;
      i_datoB = 32'd6;
      @(posedge clk);
      @(negedge clk);
      i_start = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk);
         @(negedge clk);
         // Busy through the FIX cycle, which ends at edge 37 with 5 halted edges.
         exp_stall = (k >= 3) && (k <= 37);
         if (o_stall !== exp_stall) bad_stall++;
         if (k == 20) begin
            n_tests++;
            if (o_hi !== last_hi || o_lo !== last_lo) begin
               n_fail++;
               $display("FAIL hilo_stable: got hi=%h lo=%h want hi=%h lo=%h",
                        o_hi, o_lo, last_hi, last_lo);
            end
         end
         if (o_done) begin
            done_edge = k;
            break;
         end
         if (k == 2)  i_hilo_read = 1'b1;
         if (k == 9)  i_halt = 1'b1;
         if (k == 14) i_halt = 1'b0;
      end
      n_tests++;
      if (done_edge !== 38) begin
         n_fail++;
         $display("FAIL halt_latency: got edge %0d want 38", done_edge);
      end
      n_tests++;
      if (bad_stall !== 0) begin
         n_fail++;
         $display("FAIL stall_window: got %0d wrong cycles want 0", bad_stall);
      end
      n_tests++;
      if (o_hi !== 32'd0 || o_lo !== 32'd30 || o_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL read_after_fix: got hi=%h lo=%h stall=%b want 0/1e/0",
                  o_hi, o_lo, o_stall);
      end
      i_hilo_read = 1'b0;
      last_hi = 32'd0;
      last_lo = 32'd30;
      // Halt while o_done is high: it must be held, then drop once.
      i_halt = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_tests++;
      if (o_done !== 1'b1) begin
         n_fail++;
         $display("FAIL done_held: got %b want 1", o_done);
      end
      i_halt = 1'b0;
      @(negedge clk);
      n_tests++;
      if (o_done !== 1'b0) begin
         n_fail++;
         $display("FAIL done_release: got %b want 0", o_done);
      end
   endtask

   task automatic test_reset_mid;
      int          seen_done = 0;
      logic [31:0] a, b, ehi, elo, hi, lo;
      logic        edbz, dbz;
      int          de;
      @(negedge clk);
      i_start = 1'b1;
      i_op    = 2'b10;
      i_datoA = $urandom;
      i_datoB = $urandom_range(1, 1000);
      @(posedge clk);
      @(negedge clk);
      i_start = 1'b0;
      for (int k = 1; k <= 9; k++) @(negedge clk);
      i_rst_n = 1'b0;
      #1;
      n_tests++;
      if (o_busy !== 1'b0 || o_hi !== 32'd0 || o_lo !== 32'd0 || o_done !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_state: got busy=%b hi=%h lo=%h done=%b want 0/0/0/0",
                  o_busy, o_hi, o_lo, o_done);
      end
      @(negedge clk);
      i_rst_n = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (o_done) seen_done++;
      end
      n_tests++;
      if (seen_done !== 0) begin
         n_fail++;
         $display("FAIL midreset_no_done: got %0d pulses want 0", seen_done);
      end
      a = $urandom;
      b = $urandom;
      ref_model(2'b01, a, b, ehi, elo, edbz);
      do_op(2'b01, a, b, de, hi, lo, dbz);
      n_tests++;
      if (de !== 33 || hi !== ehi || lo !== elo) begin
         n_fail++;
         $display("FAIL after_reset_op: got edge=%0d hi=%h lo=%h want 33 hi=%h lo=%h",
                  de, hi, lo, ehi, elo);
      end
      last_hi = ehi;
      last_lo = elo;
   endtask

   task automatic test_back_to_back;
      logic [31:0] a1, b1, a2, b2, ehi1, elo1, ehi2, elo2, hi1, lo1, hi2, lo2;
      logic        edbz1, edbz2;
      int          d1 = -1;
      int          d2 = -1;
      int          bad_stall = 0;
      a1 = $urandom;
      b1 = $urandom;
      a2 = $urandom;
      b2 = $urandom_range(1, 65535);
      ref_model(2'b01, a1, b1, ehi1, elo1, edbz1);
      ref_model(2'b10, a2, b2, ehi2, elo2, edbz2);
      hi1 = '0;
      lo1 = '0;
      hi2 = '0;
      lo2 = '0;
      @(negedge clk);
      i_start = 1'b1;
      i_op    = 2'b01;
      i_datoA = a1;
      i_datoB = b1;
      @(posedge clk);
      @(negedge clk);
      i_op    = 2'b10;
      i_datoA = a2;
      i_datoB = b2;
      for (int k = 1; k <= 80; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k <= 33 && o_stall !== (k <= 32)) bad_stall++;
         if (o_done) begin
            if (d1 < 0) begin
               d1  = k;
               hi1 = o_hi;
               lo1 = o_lo;
            end else if (d2 < 0) begin
               d2  = k;
               hi2 = o_hi;
               lo2 = o_lo;
            end
         end
         if (k == 34) i_start = 1'b0;
         if (d2 >= 0) break;
      end
      i_start = 1'b0;
      n_tests++;
      if (bad_stall !== 0) begin
         n_fail++;
         $display("FAIL b2b_stall: got %0d wrong cycles want 0", bad_stall);
      end
      n_tests++;
      if (d1 !== 33 || hi1 !== ehi1 || lo1 !== elo1) begin
         n_fail++;
         $display("FAIL b2b_first: got edge=%0d hi=%h lo=%h want 33 hi=%h lo=%h",
                  d1, hi1, lo1, ehi1, elo1);
      end
      n_tests++;
      if (d2 !== 67 || hi2 !== ehi2 || lo2 !== elo2) begin
         n_fail++;
         $display("FAIL b2b_second: got edge=%0d hi=%h lo=%h want 67 hi=%h lo=%h",
                  d2, hi2, lo2, ehi2, elo2);
      end
      last_hi = ehi2;
      last_lo = elo2;
   endtask

   task automatic test_random;
      logic [1:0]  op;
      logic [31:0] a, b, ehi, elo, hi, lo;
      logic        edbz, dbz;
      int          de;
      for (int i = 0; i < 16; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = $urandom_range(1, 15);
            default: ;
         endcase
         ref_model(op, a, b, ehi, elo, edbz);
         do_op(op, a, b, de, hi, lo, dbz);
         n_tests++;
         if (de !== 33 || hi !== ehi || lo !== elo || dbz !== edbz) begin
            n_fail++;
            $display("FAIL rand%0d op=%0d a=%h b=%h: got edge=%0d hi=%h lo=%h dbz=%b want 33 hi=%h lo=%h dbz=%b",
                     i, op, a, b, de, hi, lo, dbz, ehi, elo, edbz);
         end
         last_hi = ehi;
         last_lo = elo;
      end
   endtask

   initial begin
      i_rst_n     = 1'b0;
      i_halt      = 1'b0;
      i_start     = 1'b0;
      i_op        = 2'b00;
      i_datoA     = '0;
      i_datoB     = '0;
      i_hilo_read = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      i_rst_n = 1'b1;
      @(negedge clk);
      test_directed();
      test_stall_halt();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
